// File: rtl/stream_demux_1x2.sv
// One-to-two stream demultiplexer. Each output port has one registered slot, and a
// per-port counter tracks the beats delivered on that port.
module stream_demux_1x2 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic [CNT_W-1:0] a_count_q, a_count_d;
    logic [CNT_W-1:0] b_count_q, b_count_d;

    logic a_free, b_free;
    logic accept, load_a, load_b;
    logic a_hs, b_hs;

    // A slot is free when it is empty or is being drained in this same cycle.
    assign a_free = !a_valid_q || a_ready;
    assign b_free = !b_valid_q || b_ready;

    // Only the selected slot gates the input, so a stalled head beat holds back
    // everything behind it and input order is preserved.
    assign in_ready = !rst && (in_sel ? a_free : b_free);
    assign accept   = in_valid && in_ready;
    assign load_a   = accept && in_sel;
    assign load_b   = accept && !in_sel;
    assign a_hs     = a_valid_q && a_ready;
    assign b_hs     = b_valid_q && b_ready;

    // NOTE: every signal driven in always_comb is given its hold value first, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        a_data_d  = a_data_q;
        a_valid_d = a_valid_q;
        a_count_d = a_count_q;
        b_data_d  = b_data_q;
        b_valid_d = b_valid_q;
        b_count_d = b_count_q;

        if (a_hs) begin
            a_valid_d = 1'b0;
            a_count_d = a_count_q + CNT_ONE;
        end
        if (load_a) begin
            a_data_d  = in_data;
            a_valid_d = 1'b1;
        end

        if (b_hs) begin
            b_valid_d = 1'b0;
            b_count_d = b_count_q + CNT_ONE;
        end
        if (load_b) begin
            b_data_d  = in_data;
            b_valid_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples the
    // pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_data_q  <= '0;
            a_valid_q <= 1'b0;
            a_count_q <= '0;
            b_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_count_q <= '0;
        end else begin
            a_data_q  <= a_data_d;
            a_valid_q <= a_valid_d;
            a_count_q <= a_count_d;
            b_data_q  <= b_data_d;
            b_valid_q <= b_valid_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_data  = a_data_q;
    assign a_valid = a_valid_q;
    assign a_count = a_count_q;
    assign b_data  = b_data_q;
    assign b_valid = b_valid_q;
    assign b_count = b_count_q;

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Directed bench for stream_demux_1x2: a table of per-cycle vectors with hand-computed
// expectations, followed by a counter-wrap sequence and a check of the first cycle after reset.
module tb_stream_demux_1x2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [7:0]  a_count;
    logic [7:0]  b_count;

    int n_vec  = 0;
    int n_miss = 0;

    stream_demux_1x2 #(.WIDTH(32), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic        sel;
        logic [31:0] data;
        logic        ar;
        logic        br;
        logic        ir;
        logic        av;
        logic [31:0] ad;
        logic        bv;
        logic [31:0] bd;
        logic [7:0]  ac;
        logic [7:0]  bc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic iv, input logic sel,
                                input logic [31:0] data, input logic ar, input logic br,
                                input logic ir, input logic av, input logic [31:0] ad,
                                input logic bv, input logic [31:0] bd,
                                input logic [7:0] ac, input logic [7:0] bc);
        vec_t v;
        v.rst = r;  v.iv = iv; v.sel = sel; v.data = data; v.ar = ar; v.br = br;
        v.ir = ir;  v.av = av; v.ad = ad;   v.bv = bv;     v.bd = bd; v.ac = ac; v.bc = bc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic sel,
                         input logic [31:0] data, input logic ar, input logic br);
        rst = r; in_valid = iv; in_sel = sel; in_data = data; a_ready = ar; b_ready = br;
    endtask

    task automatic check_outs(input string tag, input logic av, input logic [31:0] ad,
                              input logic bv, input logic [31:0] bd,
                              input logic [7:0] ac, input logic [7:0] bc);
        check({tag, ".a_valid"}, 32'(a_valid), 32'(av));
        check({tag, ".a_data"},  a_data,       ad);
        check({tag, ".b_valid"}, 32'(b_valid), 32'(bv));
        check({tag, ".b_data"},  b_data,       bd);
        check({tag, ".a_count"}, 32'(a_count), 32'(ac));
        check({tag, ".b_count"}, 32'(b_count), 32'(bc));
    endtask

    initial begin
        string tag;
        logic [7:0] exp_bc;

        // Cycle-by-cycle table: inputs held for one cycle, in_ready checked mid-cycle,
        // and the registered outputs checked just after the following rising edge.
        //                 rst iv sel data          ar br   ir av ad            bv bd         ac     bc
        vecs.push_back(mk(1, 1, 1, 32'h5,        1, 1,  0, 0, 32'h0,        0, 32'h0,  8'd0,  8'd0));
        vecs.push_back(mk(0, 1, 1, 32'hDEADBEEF, 1, 1,  1, 1, 32'hDEADBEEF, 0, 32'h0,  8'd0,  8'd0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        1, 1,  1, 0, 32'hDEADBEEF, 0, 32'h0,  8'd1,  8'd0));
        vecs.push_back(mk(0, 1, 1, 32'h1,        1, 1,  1, 1, 32'h1,        0, 32'h0,  8'd1,  8'd0));
        vecs.push_back(mk(0, 1, 0, 32'h2,        1, 1,  1, 0, 32'h1,        1, 32'h2,  8'd2,  8'd0));
        vecs.push_back(mk(0, 1, 1, 32'h3,        1, 1,  1, 1, 32'h3,        0, 32'h2,  8'd2,  8'd1));
        vecs.push_back(mk(0, 1, 0, 32'h4,        1, 1,  1, 0, 32'h3,        1, 32'h4,  8'd3,  8'd1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1,  1, 0, 32'h3,        0, 32'h4,  8'd3,  8'd2));
        vecs.push_back(mk(0, 1, 1, 32'hA0,       1, 1,  1, 1, 32'hA0,       0, 32'h4,  8'd3,  8'd2));
        vecs.push_back(mk(0, 1, 1, 32'hA1,       1, 1,  1, 1, 32'hA1,       0, 32'h4,  8'd4,  8'd2));
        vecs.push_back(mk(0, 0, 1, 32'h0,        1, 1,  1, 0, 32'hA1,       0, 32'h4,  8'd5,  8'd2));
        // A stalled for five cycles while holding 0x11; the next sel=1 beat must wait.
        vecs.push_back(mk(0, 1, 1, 32'h11,       0, 1,  1, 1, 32'h11,       0, 32'h4,  8'd5,  8'd2));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 1, 1, 32'h22,   0, 1,  0, 1, 32'h11,       0, 32'h4,  8'd5,  8'd2));
        vecs.push_back(mk(0, 1, 1, 32'h22,       1, 1,  1, 1, 32'h22,       0, 32'h4,  8'd6,  8'd2));
        vecs.push_back(mk(0, 0, 1, 32'h0,        1, 1,  1, 0, 32'h22,       0, 32'h4,  8'd7,  8'd2));
        // Head beat for stalled A blocks a later beat for empty B.
        vecs.push_back(mk(0, 1, 1, 32'h11,       0, 1,  1, 1, 32'h11,       0, 32'h4,  8'd7,  8'd2));
        vecs.push_back(mk(0, 1, 1, 32'h33,       0, 1,  0, 1, 32'h11,       0, 32'h4,  8'd7,  8'd2));
        vecs.push_back(mk(0, 1, 1, 32'h33,       0, 1,  0, 1, 32'h11,       0, 32'h4,  8'd7,  8'd2));
        vecs.push_back(mk(0, 1, 1, 32'h33,       1, 1,  1, 1, 32'h33,       0, 32'h4,  8'd8,  8'd2));
        vecs.push_back(mk(0, 1, 0, 32'h44,       1, 1,  1, 0, 32'h33,       1, 32'h44, 8'd9,  8'd2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1,  1, 0, 32'h33,       0, 32'h44, 8'd9,  8'd3));
        // Stalled B does not hold back delivery from A.
        vecs.push_back(mk(0, 1, 0, 32'h55,       1, 0,  1, 0, 32'h33,       1, 32'h55, 8'd9,  8'd3));
        vecs.push_back(mk(0, 1, 1, 32'h66,       0, 0,  1, 1, 32'h66,       1, 32'h55, 8'd9,  8'd3));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0,  0, 0, 32'h66,       1, 32'h55, 8'd10, 8'd3));
        // Both slots full and stalled, then a one-cycle reset discards them.
        vecs.push_back(mk(0, 1, 1, 32'h77,       0, 0,  1, 1, 32'h77,       1, 32'h55, 8'd10, 8'd3));
        vecs.push_back(mk(1, 1, 1, 32'h99,       0, 0,  0, 0, 32'h0,        0, 32'h0,  8'd0,  8'd0));
        vecs.push_back(mk(0, 0, 1, 32'h0,        1, 1,  1, 0, 32'h0,        0, 32'h0,  8'd0,  8'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1,  1, 0, 32'h0,        0, 32'h0,  8'd0,  8'd0));

        drive(1, 0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("v%0d", i);
            drive(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].data, vecs[i].ar, vecs[i].br);
            @(negedge clk);
            check({tag, ".in_ready"}, 32'(in_ready), 32'(vecs[i].ir));
            @(posedge clk);
            #1;
            check_outs(tag, vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ac, vecs[i].bc);
        end

        // One beat on A, then 256 back-to-back beats on B: b_count wraps and a_count holds.
        drive(0, 1, 1, 32'hAA, 1, 1);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 32'h0, 1, 1);
        @(posedge clk);
        #1;
        check("wrap.a_count_pre", 32'(a_count), 32'd1);
        exp_bc = 8'd0;
        for (int i = 0; i < 256; i++) begin
            drive(0, 1, 0, 32'(i), 1, 1);
            @(negedge clk);
            if (in_ready !== 1'b1) check($sformatf("wrap.in_ready%0d", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            if (i > 0) exp_bc = exp_bc + 8'd1;
        end
        check("wrap.b_count_255", 32'(b_count), 32'(exp_bc));
        check("wrap.b_data_last", b_data, 32'd255);
        drive(0, 0, 0, 32'h0, 1, 1);
        @(posedge clk);
        #1;
        check("wrap.b_count_0", 32'(b_count), 32'd0);
        check("wrap.b_valid", 32'(b_valid), 32'd0);
        check("wrap.a_count", 32'(a_count), 32'd1);

        // First cycle after reset: in_ready is high for either select value.
        drive(1, 0, 1, 32'h0, 0, 0);
        @(negedge clk);
        check("rst.in_ready_forced", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 32'h0, 0, 0);
        #1;
        check("post_rst.in_ready_sel1", 32'(in_ready), 32'd1);
        in_sel = 1'b0;
        #1;
        check("post_rst.in_ready_sel0", 32'(in_ready), 32'd1);
        check_outs("post_rst", 1'b0, 32'h0, 1'b0, 32'h0, 8'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
